ddp_merge_sched: RTL and testbench
==================================

Name: ddp_merge_sched

Overview:
Clocked N-input merge scheduler for the DDP token pipeline. It shares one downstream Send/Ack channel among NUM_IN upstream bundled-data channels using round-robin arbitration. It is the synchronous counterpart of the self-timed two-way merge: same 4-phase (return-to-zero) Send/Ack semantics, generalised to N inputs, with data latching and status outputs for the pipeline controller.

Parameters:
NUM_IN, 4, number of upstream channels (2..8)
DATA_W, 32, token data width
SYNC_STAGES, 2, flop stages on each asynchronous Send_in/Ack_in (>=2)
CNT_W, 16, width of the saturating conflict counter

Ports:
CLK  in  1  clock, rising edge
MR_n  in  1  master reset, asynchronous, active-low
Send_in  in  NUM_IN  per-channel request, 4-phase, bundled with Data_in
Data_in  in  NUM_IN*DATA_W  channel i data in bits [i*DATA_W +: DATA_W], stable while Send_in[i]=1
Ack_out  out  NUM_IN  per-channel acknowledge
Send_out  out  1  downstream request
Data_out  out  DATA_W  downstream data, stable while Send_out=1
Ack_in  in  1  downstream acknowledge
Grant  out  NUM_IN  one-hot owner of current transfer, 0 when idle
Last_grant  out  $clog2(NUM_IN)  index of the last completed transfer
Busy  out  1  high in any state other than IDLE
Conflict_cnt  out  CNT_W  arbitration events with at least two requests pending, saturating

Behaviour:
- One clock; reset asynchronous, active-low (MR_n). All logic on the rising edge of CLK.
- On MR_n=0, immediately: state=IDLE, Send_out=0, Ack_out=0, Grant=0, Data_out=0, Last_grant=0, rr pointer=NUM_IN-1, Conflict_cnt=0, synchronizer flops=0.
- Send_in[*] and Ack_in pass through SYNC_STAGES flops; "req" and "ack" below are the synchronized values. Data_in is sampled directly; bundling plus the synchronizer delay guarantees it is stable.
- FSM:
  - IDLE: if req!=0, pick the first set bit scanning from (ptr+1) mod NUM_IN upward with wrap. Set Grant to one-hot(g). Latch Data_out <= Data_in[g]. Go to REQ. If popcount(req)>=2, Conflict_cnt += 1, saturating at all-ones.
  - REQ: Send_out=1. When ack=1: Send_out<=0, Ack_out[g]<=1, go to RTZ.
  - RTZ: wait until ack=0 AND req[g]=0. Then Ack_out[g]<=0, Grant<=0, Last_grant<=g, ptr<=g, go to IDLE.
- Latency:
  - Synchronized req high in IDLE at edge k gives Send_out=1 after edge k+1.
  - ack high gives Ack_out[g]=1 after the next edge.
  - Minimum back-to-back gap is one IDLE cycle between transfers.
- Only the granted channel ever sees Ack_out. Non-granted requests wait with Ack_out=0. A request that drops before being granted is simply not served.
- Data_out holds its latched value until the next grant; it does not change during REQ or RTZ.
- If ack is already high on entry to REQ (protocol violation), treat it as a normal ack on the first REQ cycle.
- If req[g] drops during REQ (protocol violation), ignore it and complete the transfer.
- Fairness: a channel with a continuously held request is granted within NUM_IN transfers.
- Reset mid-transfer aborts immediately. Outputs go to reset values; upstream and downstream must also be reset by MR.

Decomposition:
- Shared package ddp_pkg holds:
  - the state enum (IDLE, REQ, RTZ)
  - a localparam helper for index width ($clog2 with a minimum of 1)
  - function rr_pick(req, ptr), returning the granted index and a valid flag
- One sub-module, ddp_sync: a parameterised SYNC_STAGES-deep synchronizer with async active-low clear. Instantiate it once for the NUM_IN+1 bit vector {Ack_in, Send_in}.

Test Plan:
- Reset: hold MR_n=0 with Send_in=4'b1111 -> Send_out=0, Ack_out=0, Grant=0, Conflict_cnt=0. Release, and the first grant goes to channel 0.
- Single transfer: Send_in[2]=1 with Data_in[2]=32'hDEAD_BEEF; downstream acks after 3 cycles -> Send_out rises SYNC_STAGES+1 edges after Send_in, Data_out=32'hDEADBEEF, Ack_out=4'b0100, then Last_grant=2, Busy=0.
- Simultaneous requests: Send_in=4'b1011 held, each transfer completes and re-requests -> grant order 0,1,3,0,1,3; Conflict_cnt increments on every arbitration.
- Wrap-around: ptr=3, Send_in=4'b1001 -> channel 0 is granted before channel 3.
- Slow RTZ: ack drops but Send_in[g] is held 5 extra cycles -> state stays RTZ, Ack_out[g] stays 1, no new grant. Idle resumes one edge after the synchronized Send_in[g] falls.
- Mid-transfer reset: MR_n pulsed low during REQ -> Send_out falls asynchronously; Conflict_cnt and Last_grant return to 0. Counter saturation, using CNT_W=4 override with 20 conflicts -> Conflict_cnt=4'hF.

Source files
------------

// File: rtl/ddp_pkg.sv
// rtl/ddp_pkg.sv - shared types and helpers for the DDP merge scheduler
package ddp_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RTZ} state_t;

  localparam int MAX_IN = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scans downward so the last hit assigned is the first one after ptr in wrap order.
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0] req, input logic [2:0] ptr,
                                    input int n);
    pick_t      r;
    logic [2:0] i;
    r = '0;
    for (int off = n; off >= 1; off--) begin
      i = 3'((int'(ptr) + off) % n);
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ddp_sync.sv
// rtl/ddp_sync.sv - multi-stage synchronizer with asynchronous active-low clear
module ddp_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) stg[s] <= '0;
    end else begin
      stg[0] <= d;
      for (int s = 1; s < STAGES; s++) stg[s] <= stg[s-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/ddp_merge_sched.sv
// rtl/ddp_merge_sched.sv - round-robin N-input 4-phase merge onto one Send/Ack channel
module ddp_merge_sched
  import ddp_pkg::*;
#(
  parameter int NUM_IN      = 4,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                       CLK,
  input  logic                       MR_n,
  input  logic [NUM_IN-1:0]          Send_in,
  input  logic [NUM_IN*DATA_W-1:0]   Data_in,
  output logic [NUM_IN-1:0]          Ack_out,
  output logic                       Send_out,
  output logic [DATA_W-1:0]          Data_out,
  input  logic                       Ack_in,
  output logic [NUM_IN-1:0]          Grant,
  output logic [idx_w(NUM_IN)-1:0]   Last_grant,
  output logic                       Busy,
  output logic [CNT_W-1:0]           Conflict_cnt
);

  localparam int IDX_W = idx_w(NUM_IN);

  logic [NUM_IN:0]     sync_q;
  logic [NUM_IN-1:0]   req;
  logic                ack;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, gidx_q, gidx_d, last_d;
  logic                send_d;
  logic [NUM_IN-1:0]   ack_d, grant_d;
  logic [DATA_W-1:0]   data_d;
  logic [CNT_W-1:0]    cnt_d;
  pick_t               pick;

  ddp_sync #(.W(NUM_IN + 1), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLK),
    .rst_n (MR_n),
    .d     ({Ack_in, Send_in}),
    .q     (sync_q)
  );

  assign req  = sync_q[NUM_IN-1:0];
  assign ack  = sync_q[NUM_IN];
  assign Busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    last_d  = Last_grant;
    send_d  = Send_out;
    ack_d   = Ack_out;
    grant_d = Grant;
    data_d  = Data_out;
    cnt_d   = Conflict_cnt;
    pick    = rr_pick(MAX_IN'(req), 3'(ptr_q), NUM_IN);
    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          gidx_d  = IDX_W'(pick.idx);
          grant_d = NUM_IN'(1) << pick.idx;
          for (int i = 0; i < NUM_IN; i++)
            if (pick.idx == 3'(i)) data_d = Data_in[i*DATA_W +: DATA_W];
          send_d  = 1'b1;
          state_d = REQ;
          if ($countones(req) > 1 && Conflict_cnt != '1)
            cnt_d = Conflict_cnt + CNT_W'(1);
        end
      end
      // A stale ack on entry counts as the real one; a dropped req here is ignored.
      REQ: begin
        if (ack) begin
          send_d        = 1'b0;
          ack_d[gidx_q] = 1'b1;
          state_d       = RTZ;
        end
      end
      RTZ: begin
        if (!ack && !req[gidx_q]) begin
          ack_d   = '0;
          grant_d = '0;
          last_d  = gidx_q;
          ptr_d   = gidx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(NUM_IN - 1);
      gidx_q       <= '0;
      Last_grant   <= '0;
      Send_out     <= 1'b0;
      Ack_out      <= '0;
      Grant        <= '0;
      Data_out     <= '0;
      Conflict_cnt <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      Last_grant   <= last_d;
      Send_out     <= send_d;
      Ack_out      <= ack_d;
      Grant        <= grant_d;
      Data_out     <= data_d;
      Conflict_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ddp_merge_sched.sv
// tb/tb_ddp_merge_sched.sv - directed self-checking bench for ddp_merge_sched
module tb_ddp_merge_sched;

  logic          CLK;
  logic          MR_n;
  logic [3:0]    Send_in;
  logic [127:0]  Data_in;
  logic          Ack_in;

  logic [3:0]    Ack_out, Grant;
  logic          Send_out, Busy;
  logic [31:0]   Data_out;
  logic [1:0]    Last_grant;
  logic [15:0]   Conflict_cnt;

  logic [3:0]    Ack_out4, Grant4;
  logic          Send_out4, Busy4;
  logic [31:0]   Data_out4;
  logic [1:0]    Last_grant4;
  logic [3:0]    Conflict_cnt4;

  int checks = 0;
  int failures = 0;

  ddp_merge_sched dut (
    .CLK(CLK), .MR_n(MR_n), .Send_in(Send_in), .Data_in(Data_in), .Ack_out(Ack_out),
    .Send_out(Send_out), .Data_out(Data_out), .Ack_in(Ack_in), .Grant(Grant),
    .Last_grant(Last_grant), .Busy(Busy), .Conflict_cnt(Conflict_cnt)
  );

  ddp_merge_sched #(.CNT_W(4)) dut4 (
    .CLK(CLK), .MR_n(MR_n), .Send_in(Send_in), .Data_in(Data_in), .Ack_out(Ack_out4),
    .Send_out(Send_out4), .Data_out(Data_out4), .Ack_in(Ack_in), .Grant(Grant4),
    .Last_grant(Last_grant4), .Busy(Busy4), .Conflict_cnt(Conflict_cnt4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_data(input int g);
    case (g)
      0:       return 32'h1111_0000;
      1:       return 32'h2222_0001;
      2:       return 32'hDEAD_BEEF;
      default: return 32'h4444_0003;
    endcase
  endfunction

  // Plays both the downstream receiver and the granted upstream sender for one transfer.
  task automatic xfer(input int g, input bit rereq);
    int n;
    n = 0;
    while (Send_out !== 1'b1 && n < 40) begin tick(); n++; end
    check("send_out_rise", 64'(Send_out), 64'(1));
    check("grant", 64'(Grant), 64'(4'b0001 << g));
    check("data_out", 64'(Data_out), 64'(exp_data(g)));
    Ack_in = 1'b1;
    n = 0;
    while (Ack_out === 4'b0000 && n < 40) begin tick(); n++; end
    check("ack_out", 64'(Ack_out), 64'(4'b0001 << g));
    check("send_out_fall", 64'(Send_out), 64'(0));
    check("data_hold", 64'(Data_out), 64'(exp_data(g)));
    Ack_in  = 1'b0;
    Send_in = Send_in & ~(4'b0001 << g);
    n = 0;
    while (Busy !== 1'b0 && n < 40) begin tick(); n++; end
    check("idle_busy", 64'(Busy), 64'(0));
    check("last_grant", 64'(Last_grant), 64'(g));
    check("grant_clear", 64'(Grant), 64'(0));
    check("ack_clear", 64'(Ack_out), 64'(0));
    if (rereq) Send_in = Send_in | (4'b0001 << g);
  endtask

  initial begin
    int n;
    Data_in = {32'h4444_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
    Ack_in  = 1'b0;
    Send_in = 4'b1111;
    MR_n    = 1'b0;

    // Reset holds everything quiet even with all requests up.
    repeat (3) tick();
    check("rst_send_out", 64'(Send_out), 64'(0));
    check("rst_ack_out", 64'(Ack_out), 64'(0));
    check("rst_grant", 64'(Grant), 64'(0));
    check("rst_cnt", 64'(Conflict_cnt), 64'(0));
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_last", 64'(Last_grant), 64'(0));
    MR_n = 1'b1;
    n = 0;
    while (Send_out !== 1'b1 && n < 40) begin tick(); n++; end
    Send_in = 4'b0001;
    xfer(0, 1'b0);
    check("cnt_after_first", 64'(Conflict_cnt), 64'(1));

    // Single transfer latency and data.
    tick();
    Send_in = 4'b0100;
    n = 0;
    do begin tick(); n++; end while (Send_out !== 1'b1 && n < 20);
    check("send_latency", 64'(n), 64'(3));
    xfer(2, 1'b0);
    check("cnt_single", 64'(Conflict_cnt), 64'(1));

    // Move pointer to 3, then wrap-around: channel 0 before 3.
    Send_in = 4'b1000;
    xfer(3, 1'b0);
    Send_in = 4'b1001;
    xfer(0, 1'b0);
    xfer(3, 1'b0);
    check("cnt_wrap", 64'(Conflict_cnt), 64'(2));

    // Three held requests rotate 0,1,3.
    Send_in = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0:       xfer(0, i < 5);
        1:       xfer(1, i < 5);
        default: xfer(3, i < 5);
      endcase
    end
    check("cnt_rr6", 64'(Conflict_cnt), 64'(8));
    Send_in = 4'b0000;
    xfer(0, 1'b0);
    check("cnt_rr7", 64'(Conflict_cnt), 64'(9));

    // Slow return-to-zero on the upstream side.
    tick();
    Send_in = 4'b0010;
    n = 0;
    while (Send_out !== 1'b1 && n < 40) begin tick(); n++; end
    check("slow_grant", 64'(Grant), 64'(4'b0010));
    Ack_in = 1'b1;
    n = 0;
    while (Ack_out === 4'b0000 && n < 40) begin tick(); n++; end
    Ack_in = 1'b0;
    repeat (5) tick();
    check("slow_busy", 64'(Busy), 64'(1));
    check("slow_ack_held", 64'(Ack_out), 64'(4'b0010));
    check("slow_grant_held", 64'(Grant), 64'(4'b0010));
    check("slow_no_send", 64'(Send_out), 64'(0));
    Send_in = 4'b0000;
    n = 0;
    do begin tick(); n++; end while (Busy !== 1'b0 && n < 20);
    check("slow_idle_latency", 64'(n), 64'(3));
    check("slow_last", 64'(Last_grant), 64'(1));

    // Asynchronous reset in the middle of REQ.
    Send_in = 4'b0100;
    n = 0;
    while (Send_out !== 1'b1 && n < 40) begin tick(); n++; end
    check("mid_send_up", 64'(Send_out), 64'(1));
    #2 MR_n = 1'b0;
    #1;
    check("mid_send_out", 64'(Send_out), 64'(0));
    check("mid_cnt", 64'(Conflict_cnt), 64'(0));
    check("mid_last", 64'(Last_grant), 64'(0));
    check("mid_grant", 64'(Grant), 64'(0));
    check("mid_busy", 64'(Busy), 64'(0));
    Send_in = 4'b0000;
    repeat (2) tick();
    MR_n = 1'b1;
    tick();

    // Twenty conflicting arbitrations: wide counter counts, narrow one saturates.
    Send_in = 4'b0111;
    for (int i = 0; i < 20; i++) xfer(i % 3, 1'b1);
    check("cnt_20", 64'(Conflict_cnt), 64'(20));
    check("cnt4_sat", 64'(Conflict_cnt4), 64'(4'hF));
    Send_in = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
